// File: rtl/wb_aperture_ctrl.sv
// wb_aperture_ctrl
//   Wishbone client-side aperture controller between the AHB-to-FPGA bridge
//   and three FPGA client blocks (fabric registers, UART0, QL reserved).
//   Decodes the byte address into a one-hot client select, routes the chosen
//   client's ack/read data back to the bridge, and terminates unmapped or
//   unanswered accesses with a default ack so the bridge never stalls.
//   The first error is logged until it is cleared.
//
// Ports
//   WB_CLK, WB_RST_N        bus clock, async active-low reset
//   WBs_ADR/CYC/STB         bridge request (byte address)
//   WBs_RD_DAT, WBs_ACK     response to bridge
//   Cli_CYC_o               one-hot client cycle (0 FPGA reg, 1 UART0, 2 QL)
//   Cli_ACK_i, Cli_RD_DAT_i client responses (client n at [32n+31:32n])
//   Bus_Err_o, Err_Type_o   sticky error flag, 0 unmapped / 1 timeout
//   Err_Adr_o               address of first logged error
//   Err_Clr_i               synchronous log clear
//
// state  | meaning
// IDLE   | no transfer; decode a new request
// ACTIVE | client selected, waiting for its ack or the timeout
// DFLT   | one-cycle default termination back to the bridge

module wb_aperture_ctrl #(
  parameter int                  APERWIDTH                = 17,
  parameter int                  APERSIZE                 = 10,
  parameter logic [APERWIDTH-1:0] FPGA_REG_BASE_ADDRESS   = 17'h00000,
  parameter logic [APERWIDTH-1:0] UART0_BASE_ADDRESS      = 17'h01000,
  parameter logic [APERWIDTH-1:0] QL_RESERVED_BASE_ADDRESS = 17'h12000,
  parameter logic [31:0]         DEFAULT_READ_VALUE       = 32'hBADFABAC,
  parameter int                  DEFAULT_CNTR_WIDTH       = 3,
  parameter int                  DEFAULT_CNTR_TIMEOUT     = 7
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_N,
  input  logic [APERWIDTH-1:0] WBs_ADR,
  input  logic                 WBs_CYC,
  input  logic                 WBs_STB,
  output logic [31:0]          WBs_RD_DAT,
  output logic                 WBs_ACK,
  output logic [2:0]           Cli_CYC_o,
  input  logic [2:0]           Cli_ACK_i,
  input  logic [95:0]          Cli_RD_DAT_i,
  output logic                 Bus_Err_o,
  output logic                 Err_Type_o,
  output logic [APERWIDTH-1:0] Err_Adr_o,
  input  logic                 Err_Clr_i
);

  localparam int HI = APERWIDTH - 1;
  localparam int LO = APERSIZE + 2;
  localparam logic [DEFAULT_CNTR_WIDTH-1:0] TIMEOUT_CNT =
    DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DFLT = 2'd2} state_t;

  state_t                        state, state_nxt;
  logic [2:0]                    sel, sel_nxt;
  logic [DEFAULT_CNTR_WIDTH-1:0] cnt, cnt_nxt;
  logic [APERWIDTH-1:0]          adr_q, adr_nxt;

  logic [2:0]           hit, hit_pri;
  logic                 req;
  logic                 cli_ack;
  logic [31:0]          cli_dat;
  logic                 err_new;
  logic                 err_new_type;
  logic [APERWIDTH-1:0] err_new_adr;

  assign req = WBs_CYC & WBs_STB;

  assign hit[0] = (WBs_ADR[HI:LO] == FPGA_REG_BASE_ADDRESS[HI:LO]);
  assign hit[1] = (WBs_ADR[HI:LO] == UART0_BASE_ADDRESS[HI:LO]);
  assign hit[2] = (WBs_ADR[HI:LO] == QL_RESERVED_BASE_ADDRESS[HI:LO]);

  // Lower client index wins if apertures are configured to overlap.
  always_comb begin
    hit_pri = 3'b000;
    if (hit[0])      hit_pri = 3'b001;
    else if (hit[1]) hit_pri = 3'b010;
    else if (hit[2]) hit_pri = 3'b100;
  end

  // sel is one-hot (or zero), so an AND-OR mux is sufficient.
  assign cli_ack = |(Cli_ACK_i & sel);

  always_comb begin
    cli_dat = 32'h0;
    for (int n = 0; n < 3; n++) begin
      if (sel[n]) cli_dat = cli_dat | Cli_RD_DAT_i[32*n +: 32];
    end
  end

  // State register
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state <= IDLE;
      sel   <= 3'b000;
      cnt   <= '0;
      adr_q <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      adr_q <= adr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    adr_nxt      = adr_q;
    err_new      = 1'b0;
    err_new_type = 1'b0;
    err_new_adr  = WBs_ADR;
    case (state)
      IDLE: begin
        if (req) begin
          adr_nxt = WBs_ADR;
          if (|hit_pri) begin
            sel_nxt   = hit_pri;
            cnt_nxt   = '0;
            state_nxt = ACTIVE;
          end else begin
            err_new   = 1'b1;
            state_nxt = DFLT;
          end
        end
      end
      ACTIVE: begin
        // Client ack outranks the timeout on the final count.
        if (cli_ack) begin
          state_nxt = IDLE;
        end else if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          err_new      = 1'b1;
          err_new_type = 1'b1;
          err_new_adr  = adr_q;
          state_nxt    = DFLT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DFLT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    Cli_CYC_o  = 3'b000;
    WBs_ACK    = 1'b0;
    WBs_RD_DAT = 32'h0;
    case (state)
      ACTIVE: begin
        Cli_CYC_o  = sel;
        WBs_ACK    = cli_ack;
        WBs_RD_DAT = cli_dat;
      end
      DFLT: begin
        WBs_ACK    = 1'b1;
        WBs_RD_DAT = DEFAULT_READ_VALUE;
      end
      default: ;
    endcase
  end

  // Error log: first error sticks; a new error in the clear cycle re-arms it.
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      Bus_Err_o  <= 1'b0;
      Err_Type_o <= 1'b0;
      Err_Adr_o  <= '0;
    end else if (err_new && (!Bus_Err_o || Err_Clr_i)) begin
      Bus_Err_o  <= 1'b1;
      Err_Type_o <= err_new_type;
      Err_Adr_o  <= err_new_adr;
    end else if (Err_Clr_i) begin
      Bus_Err_o  <= 1'b0;
      Err_Type_o <= 1'b0;
      Err_Adr_o  <= '0;
    end
  end

endmodule

// File: tb/tb_wb_aperture_ctrl.sv
module tb_wb_aperture_ctrl;

  logic        WB_CLK = 1'b0;
  logic        WB_RST_N;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC;
  logic        WBs_STB;
  logic [31:0] WBs_RD_DAT;
  logic        WBs_ACK;
  logic [2:0]  Cli_CYC_o;
  logic [2:0]  Cli_ACK_i;
  logic [95:0] Cli_RD_DAT_i;
  logic        Bus_Err_o;
  logic        Err_Type_o;
  logic [16:0] Err_Adr_o;
  logic        Err_Clr_i;

  localparam logic [31:0] DEF   = 32'hBADFABAC;
  localparam logic [31:0] DAT0  = 32'hC0C0_0000;
  localparam logic [31:0] DAT1  = 32'h0000_0041;
  localparam logic [31:0] DAT2  = 32'hC2C2_0002;

  wb_aperture_ctrl dut (
    .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N),
    .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB),
    .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
    .Cli_CYC_o(Cli_CYC_o), .Cli_ACK_i(Cli_ACK_i), .Cli_RD_DAT_i(Cli_RD_DAT_i),
    .Bus_Err_o(Bus_Err_o), .Err_Type_o(Err_Type_o), .Err_Adr_o(Err_Adr_o),
    .Err_Clr_i(Err_Clr_i)
  );

  always #5 WB_CLK = ~WB_CLK;

  typedef struct {
    logic [16:0] adr;
    int          stb_drop;  // cycle from which STB is low, -1 = never
    logic [2:0]  ack_mask;  // Cli_ACK_i in cycle ack_at
    int          ack_at;    // -1 = client never acks
    logic [2:0]  stray;     // Cli_ACK_i in every other cycle
    int          clr_at;    // cycle with Err_Clr_i high, -1 = none
    int          exp_ack;   // expected WBs_ACK cycle, -1 = none
    logic [31:0] exp_dat;
    logic [2:0]  exp_cyc;   // Cli_CYC_o expected in cycle 1
    logic        exp_err;
    logic        exp_type;
    logic [16:0] exp_eadr;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } sb_t;

  sb_t sb_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [16:0] adr, input int stb_drop,
                              input logic [2:0] ack_mask, input int ack_at,
                              input logic [2:0] stray, input int clr_at,
                              input int exp_ack, input logic [31:0] exp_dat,
                              input logic [2:0] exp_cyc, input logic exp_err,
                              input logic exp_type, input logic [16:0] exp_eadr);
    vec_t v;
    v.adr = adr; v.stb_drop = stb_drop; v.ack_mask = ack_mask; v.ack_at = ack_at;
    v.stray = stray; v.clr_at = clr_at; v.exp_ack = exp_ack; v.exp_dat = exp_dat;
    v.exp_cyc = exp_cyc; v.exp_err = exp_err; v.exp_type = exp_type; v.exp_eadr = exp_eadr;
    return v;
  endfunction

  // Cycle 0 is the first request cycle, seen by the DUT in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    sb_t e, got;
    bit  done = 0;
    if (v.exp_ack >= 0) begin
      e.cyc = v.exp_ack;
      e.dat = v.exp_dat;
      sb_q.push_back(e);
    end
    for (int c = 0; c < 14 && !done; c++) begin
      @(posedge WB_CLK);
      #1;
      WBs_ADR   = v.adr;
      WBs_CYC   = 1'b1;
      WBs_STB   = (v.stb_drop < 0 || c < v.stb_drop);
      Cli_ACK_i = (c == v.ack_at) ? v.ack_mask : v.stray;
      Err_Clr_i = (c == v.clr_at);
      @(negedge WB_CLK);
      if (c == 1) chk($sformatf("v%0d cyc_sel", idx), 32'(Cli_CYC_o), 32'(v.exp_cyc));
      if (WBs_ACK) begin
        done = 1;
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_ack_cycle", idx), 32'(c), 32'hFFFF_FFFF);
        end else begin
          got = sb_q.pop_front();
          chk($sformatf("v%0d ack_cycle", idx), 32'(c), 32'(got.cyc));
          chk($sformatf("v%0d rd_dat", idx), WBs_RD_DAT, got.dat);
        end
      end
    end
    if (sb_q.size() != 0) begin
      chk($sformatf("v%0d ack_missing", idx), 32'(0), 32'(1));
      sb_q.delete();
    end
    chk($sformatf("v%0d bus_err", idx), 32'(Bus_Err_o), 32'(v.exp_err));
    chk($sformatf("v%0d err_type", idx), 32'(Err_Type_o), 32'(v.exp_type));
    chk($sformatf("v%0d err_adr", idx), 32'(Err_Adr_o), 32'(v.exp_eadr));
  endtask

  task automatic go_idle();
    @(posedge WB_CLK);
    #1;
    WBs_CYC = 1'b0; WBs_STB = 1'b0; Cli_ACK_i = 3'b000; Err_Clr_i = 1'b0;
  endtask

  vec_t vecs[11];
  vec_t post_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                adr        drop ackm    at  stray   clr exp  data  cyc     err  typ eadr
    vecs[0]  = mk(17'h01004, -1, 3'b010, 3, 3'b000, -1, 3, DAT1, 3'b010, 1'b0, 1'b0, 17'h00000);
    vecs[1]  = mk(17'h08000, -1, 3'b000,-1, 3'b000, -1, 1, DEF,  3'b000, 1'b1, 1'b0, 17'h08000);
    vecs[2]  = mk(17'h12000, -1, 3'b000,-1, 3'b000, -1, 9, DEF,  3'b100, 1'b1, 1'b0, 17'h08000);
    vecs[3]  = mk(17'h12000, -1, 3'b000,-1, 3'b000,  0, 9, DEF,  3'b100, 1'b1, 1'b1, 17'h12000);
    vecs[4]  = mk(17'h00010, -1, 3'b001, 8, 3'b100,  0, 8, DAT0, 3'b001, 1'b0, 1'b0, 17'h00000);
    vecs[5]  = mk(17'h01008,  2, 3'b000,-1, 3'b000, -1,-1, 32'h0,3'b010, 1'b0, 1'b0, 17'h00000);
    vecs[6]  = mk(17'h08004, -1, 3'b000,-1, 3'b000, -1, 1, DEF,  3'b000, 1'b1, 1'b0, 17'h08004);
    vecs[7]  = mk(17'h0C000, -1, 3'b000,-1, 3'b000,  0, 1, DEF,  3'b000, 1'b1, 1'b0, 17'h0C000);
    vecs[8]  = mk(17'h12FFC, -1, 3'b100, 1, 3'b011, -1, 1, DAT2, 3'b100, 1'b1, 1'b0, 17'h0C000);
    vecs[9]  = mk(17'h00FFC, -1, 3'b001, 5, 3'b000, -1, 5, DAT0, 3'b001, 1'b1, 1'b0, 17'h0C000);
    vecs[10] = mk(17'h01FFC, -1, 3'b010, 2, 3'b101, -1, 2, DAT1, 3'b010, 1'b1, 1'b0, 17'h0C000);
    post_rst = mk(17'h00000, -1, 3'b001, 2, 3'b000, -1, 2, DAT0, 3'b001, 1'b0, 1'b0, 17'h00000);

    WB_RST_N = 1'b0;
    WBs_ADR = '0; WBs_CYC = 1'b0; WBs_STB = 1'b0;
    Cli_ACK_i = 3'b000; Err_Clr_i = 1'b0;
    Cli_RD_DAT_i = {DAT2, DAT1, DAT0};

    #3;
    chk("rst ack", 32'(WBs_ACK), 32'(0));
    chk("rst rd_dat", WBs_RD_DAT, 32'h0);
    chk("rst cli_cyc", 32'(Cli_CYC_o), 32'(0));
    chk("rst bus_err", 32'(Bus_Err_o), 32'(0));
    chk("rst err_adr", 32'(Err_Adr_o), 32'(0));
    #20 WB_RST_N = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
    go_idle();
    @(negedge WB_CLK);
    chk("idle rd_dat", WBs_RD_DAT, 32'h0);

    // Asynchronous reset in the middle of an ACTIVE transfer.
    @(posedge WB_CLK);
    #1;
    WBs_ADR = 17'h01000; WBs_CYC = 1'b1; WBs_STB = 1'b1;
    @(posedge WB_CLK);
    #1;
    @(negedge WB_CLK);
    chk("pre_rst cli_cyc", 32'(Cli_CYC_o), 32'(3'b010));
    chk("pre_rst bus_err", 32'(Bus_Err_o), 32'(1));
    #2;
    WB_RST_N = 1'b0;
    Cli_ACK_i = 3'b010;
    #1;
    chk("mid_rst cli_cyc", 32'(Cli_CYC_o), 32'(0));
    chk("mid_rst ack", 32'(WBs_ACK), 32'(0));
    chk("mid_rst bus_err", 32'(Bus_Err_o), 32'(0));
    chk("mid_rst err_adr", 32'(Err_Adr_o), 32'(0));
    WBs_CYC = 1'b0; WBs_STB = 1'b0; Cli_ACK_i = 3'b000;
    #10 WB_RST_N = 1'b1;

    run_vec(11, post_rst);
    go_idle();
    @(negedge WB_CLK);
    chk("final cli_cyc", 32'(Cli_CYC_o), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_aperture_ctrl.md
Name: wb_aperture_ctrl

Overview:
- Wishbone client-side controller between the AHB-to-FPGA bridge (WBs_* bus) and up to three FPGA client blocks: fabric registers, UART0 and the QL-reserved block.
- Decodes the byte address into a one-hot client select and gates per-client cycle strobes.
- Muxes client read data and acknowledge back to the bridge.
- Terminates unmapped or unanswered accesses with a default acknowledge and read value, so the bridge never hangs; the first offending access is logged.

Parameters:
- APERWIDTH, 17: WBs_ADR width (byte address).
- APERSIZE, 10: word-address bits per client aperture; each aperture spans 2^(APERSIZE+2) bytes.
- FPGA_REG_BASE_ADDRESS, 17'h00000: client 0 base.
- UART0_BASE_ADDRESS, 17'h01000: client 1 base.
- QL_RESERVED_BASE_ADDRESS, 17'h12000: client 2 base.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC: read data returned on default termination.
- DEFAULT_CNTR_WIDTH, 3: timeout counter width.
- DEFAULT_CNTR_TIMEOUT, 7: last ACTIVE count value at which a client ack is still accepted.

Ports:
- WB_CLK  in  1  bus clock.
- WB_RST_N  in  1  asynchronous active-low reset.
- WBs_ADR  in  APERWIDTH  byte address.
- WBs_CYC  in  1  cycle.
- WBs_STB  in  1  strobe.
- WBs_RD_DAT  out  32  read data to bridge.
- WBs_ACK  out  1  acknowledge to bridge.
- Cli_CYC_o  out  3  one-hot client cycle select; bit 0 = FPGA reg, bit 1 = UART0, bit 2 = QL reserved.
- Cli_ACK_i  in  3  client acks.
- Cli_RD_DAT_i  in  96  client read data; client n occupies bits [32n+31:32n].
- Bus_Err_o  out  1  sticky error flag.
- Err_Type_o  out  1  0 = unmapped, 1 = timeout.
- Err_Adr_o  out  APERWIDTH  address of first error.
- Err_Clr_i  in  1  synchronous clear of the error log.

Behaviour:
- Reset (WB_RST_N = 0, asynchronous, takes effect immediately including mid-transfer):
  - State goes to IDLE.
  - WBs_ACK = 0, WBs_RD_DAT = 0, Cli_CYC_o = 0.
  - Bus_Err_o = 0, Err_Type_o = 0, Err_Adr_o = 0, timeout counter = 0.
- Decode: client n hits when WBs_ADR[APERWIDTH-1:APERSIZE+2] equals BASE_n over the same bits.
  - If bases overlap, priority is client 0 > client 1 > client 2.
- Request: req = WBs_CYC & WBs_STB. Reads and writes are handled identically; a write terminated in DFLT is discarded.
- State machine (registered state, select and counter):
  - IDLE: Cli_CYC_o = 0, WBs_ACK = 0.
    - req with a hit: latch the select, cnt = 0, go to ACTIVE.
    - req with no hit: log an unmapped error, go to DFLT.
  - ACTIVE: Cli_CYC_o = latched one-hot select.
    - WBs_ACK = Cli_ACK_i[sel] and WBs_RD_DAT = Cli_RD_DAT_i[sel], both combinational and passed through in the same cycle.
    - Transitions, in priority order:
      - Cli_ACK_i[sel]: go to IDLE.
      - req low (host abort): go to IDLE with no ack and no error.
      - cnt == DEFAULT_CNTR_TIMEOUT: log a timeout error, go to DFLT.
      - otherwise: cnt + 1.
    - Acks on non-selected Cli_ACK_i bits are ignored.
  - DFLT: Cli_CYC_o = 0, WBs_ACK = 1 and WBs_RD_DAT = DEFAULT_READ_VALUE for exactly one cycle, then IDLE.
- Latency:
  - Mapped access with a client responding in k cycles of ACTIVE: WBs_ACK in cycle 1 + k, where cycle 0 is the first req cycle in IDLE.
  - Unmapped access: ACK in cycle 1.
  - Timeout: ACTIVE occupies cycles 1..8 and the default ACK is in cycle 9 (with TIMEOUT = 7).
  - An ack in ACTIVE cycle 8 (cnt = 7) is still accepted and takes priority over timeout.
- Back-to-back: after any ack the FSM is in IDLE the next cycle; a new req is decoded there, so there is no extra dead cycle beyond decode.
- WBs_RD_DAT = 0 whenever the state is IDLE.
- Error log:
  - Captures Err_Type_o and Err_Adr_o only while Bus_Err_o = 0; later errors do not overwrite the log.
  - Err_Clr_i clears Bus_Err_o, Err_Type_o and Err_Adr_o.
  - If Err_Clr_i and a new error occur in the same cycle, the new error wins: the flag is set and the new address and type are captured.

Test Plan:
1. Read 17'h01004 with UART ack 2 cycles after Cli_CYC_o[1] rises, Cli_RD_DAT_i[63:32] = 32'h0000_0041 -> Cli_CYC_o = 3'b010; WBs_ACK in cycle 3 with WBs_RD_DAT = 32'h41; Bus_Err_o stays 0.
2. Read 17'h08000 (unmapped) -> Cli_CYC_o stays 0; WBs_ACK in cycle 1 with 32'hBAD_FAB_AC; Bus_Err_o = 1, Err_Type_o = 0, Err_Adr_o = 17'h08000.
3. Write 17'h12000 with no client ack -> Cli_CYC_o = 3'b100 for cycles 1..8; ACK in cycle 9; Bus_Err_o stays 1 but the log keeps 17'h08000 from scenario 2; after Err_Clr_i, a repeat of this write logs Err_Type_o = 1, Err_Adr_o = 17'h12000.
4. Client 0 acks at cnt = 7 -> client ack accepted in cycle 8, no default ack, no error; also verify an ack on Cli_ACK_i[2] while sel = 0 is ignored.
5. Drop WBs_STB in ACTIVE cycle 2 -> IDLE next cycle, no WBs_ACK, no error; Err_Clr_i asserted in the same cycle as an unmapped decode -> Bus_Err_o remains 1 with the new address.
6. Deassert WB_RST_N mid-ACTIVE -> Cli_CYC_o, WBs_ACK and Bus_Err_o go to 0 immediately; after release, a new access to 17'h00000 completes normally.
